// File: rtl/pwm_duty_pkg.sv
// pwm_duty_pkg: shared types and reset defaults for the PWM duty controller
package pwm_duty_pkg;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] DEF_HIGH = 8'd6;
    localparam logic [CNT_W-1:0] DEF_LOW = 8'd4;
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    typedef struct packed {
        logic [CNT_W-1:0] high;
        logic [CNT_W-1:0] low;
    } duty_cfg_t;
endpackage

// File: rtl/pwm_cfg_shadow.sv
// pwm_cfg_shadow: config handshake, zero check, pending shadow and apply-on-strobe active register
module pwm_cfg_shadow #(
    parameter logic [pwm_duty_pkg::CNT_W-1:0] DEF_HIGH = pwm_duty_pkg::DEF_HIGH,
    parameter logic [pwm_duty_pkg::CNT_W-1:0] DEF_LOW = pwm_duty_pkg::DEF_LOW
) (
    input  logic clock,
    input  logic reset_n,
    input  logic cfg_valid,
    input  logic [pwm_duty_pkg::CNT_W-1:0] cfg_high,
    input  logic [pwm_duty_pkg::CNT_W-1:0] cfg_low,
    input  logic apply,
    output logic cfg_ready,
    output logic cfg_err,
    output pwm_duty_pkg::duty_cfg_t act_cfg,
    output pwm_duty_pkg::duty_cfg_t next_cfg
);
    import pwm_duty_pkg::*;
    logic pend_v_q;
    logic err_q;
    duty_cfg_t pend_q;
    duty_cfg_t act_q;
    logic accept;
    logic bad;
    assign cfg_ready = !pend_v_q;
    assign cfg_err = err_q;
    assign act_cfg = act_q;
    assign accept = cfg_valid && cfg_ready;
    assign bad = cfg_high == '0 || cfg_low == '0;
    // the period that starts on an apply strobe must already use the pending values
    assign next_cfg = pend_v_q ? pend_q : act_q;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_v_q <= 1'b0;
            pend_q <= '0;
            act_q <= '{high: DEF_HIGH, low: DEF_LOW};
            err_q <= 1'b0;
        end else begin
            err_q <= accept && bad;
            if (apply) act_q <= next_cfg;
            if (accept && !bad) begin
                pend_q <= '{high: cfg_high, low: cfg_low};
                pend_v_q <= 1'b1;
            end else if (apply) begin
                pend_v_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl: glitch-free PWM generator with config applied only at period boundaries
module pwm_duty_ctrl #(
    parameter logic [pwm_duty_pkg::CNT_W-1:0] DEF_HIGH = pwm_duty_pkg::DEF_HIGH,
    parameter logic [pwm_duty_pkg::CNT_W-1:0] DEF_LOW = pwm_duty_pkg::DEF_LOW
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic cfg_valid,
    output logic cfg_ready,
    input  logic [pwm_duty_pkg::CNT_W-1:0] cfg_high,
    input  logic [pwm_duty_pkg::CNT_W-1:0] cfg_low,
    output logic cfg_err,
    output logic pwm_out,
    output logic period_start,
    output logic busy
);
    import pwm_duty_pkg::*;
    state_t state_q;
    logic [CNT_W-1:0] cnt_q;
    logic at_end;
    logic start;
    duty_cfg_t act_cfg;
    duty_cfg_t next_cfg;
    assign at_end = cnt_q == '0;
    assign start = enable && (state_q == IDLE || (state_q == LOW && at_end));
    assign busy = state_q != IDLE;
    pwm_cfg_shadow #(.DEF_HIGH(DEF_HIGH), .DEF_LOW(DEF_LOW)) u_shadow (
        .clock(clock),
        .reset_n(reset_n),
        .cfg_valid(cfg_valid),
        .cfg_high(cfg_high),
        .cfg_low(cfg_low),
        .apply(start),
        .cfg_ready(cfg_ready),
        .cfg_err(cfg_err),
        .act_cfg(act_cfg),
        .next_cfg(next_cfg)
    );
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            pwm_out <= 1'b0;
            period_start <= 1'b0;
        end else begin
            period_start <= start;
            if (start) begin
                state_q <= HIGH;
                pwm_out <= 1'b1;
                cnt_q <= next_cfg.high - 1'b1;
            end else if (state_q != IDLE && !at_end) begin
                cnt_q <= cnt_q - 1'b1;
            end else if (state_q == HIGH) begin
                state_q <= LOW;
                pwm_out <= 1'b0;
                cnt_q <= act_cfg.low - 1'b1;
            end else if (state_q == LOW) begin
                state_q <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb_pwm_duty_ctrl: scoreboarded random and directed bench against a period-list reference model
module tb_pwm_duty_ctrl;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic cfg_valid = 1'b0;
    logic [7:0] cfg_high = '0;
    logic [7:0] cfg_low = '0;
    logic cfg_ready, cfg_err, pwm_out, period_start, busy;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [4:0] expq[$];
    bit wave[$];
    bit m_pend_v;
    logic [7:0] m_ah, m_al, m_ph, m_pl;
    bit m_last_pwm, m_last_ps;

    pwm_duty_ctrl dut (
        .clock(clock),
        .reset_n(reset_n),
        .enable(enable),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_high(cfg_high),
        .cfg_low(cfg_low),
        .cfg_err(cfg_err),
        .pwm_out(pwm_out),
        .period_start(period_start),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got{pwm,ps,busy,rdy,err}=%b exp=%b", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        wave.delete();
        m_pend_v = 0;
        m_ah = 8'd6;
        m_al = 8'd4;
        m_ph = 0;
        m_pl = 0;
        m_last_pwm = 0;
        m_last_ps = 0;
    endtask

    // one clock of stimulus: the model consumes a precomputed period waveform
    task automatic step(input bit en, input bit cv, input logic [7:0] ch, input logic [7:0] cl);
        bit rdy, err, st, pw, bs;
        @(negedge clock);
        enable = en;
        cfg_valid = cv;
        cfg_high = ch;
        cfg_low = cl;
        rdy = !m_pend_v;
        err = cv && rdy && (ch == 0 || cl == 0);
        st = 0;
        if (wave.size() == 0 && en) begin
            if (m_pend_v) begin
                m_ah = m_ph;
                m_al = m_pl;
                m_pend_v = 0;
            end
            repeat (m_ah) wave.push_back(1'b1);
            repeat (m_al) wave.push_back(1'b0);
            st = 1;
        end
        bs = wave.size() != 0;
        pw = bs ? wave.pop_front() : 1'b0;
        if (cv && rdy && !err) begin
            m_ph = ch;
            m_pl = cl;
            m_pend_v = 1;
        end
        expq.push_back({pw, st, bs, !m_pend_v, err});
        m_last_pwm = pw;
        m_last_ps = st;
    endtask

    task automatic run(input int n, input bit en);
        for (int i = 0; i < n; i++) step(en, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic run_to_high_mid();
        for (int i = 0; i < 600 && !(m_last_pwm && !m_last_ps); i++) step(1'b1, 1'b0, 8'd0, 8'd0);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (expq.size() != 0) check("scoreboard", {pwm_out, period_start, busy, cfg_ready, cfg_err}, expq.pop_front());
        end
    end

    initial begin
        model_reset();
        #1;
        check("reset_outputs", {pwm_out, period_start, busy, cfg_ready, cfg_err}, 5'b00010);
        @(negedge clock);
        reset_n = 1'b1;
        run(60, 1'b1);
        run_to_high_mid();
        step(1'b1, 1'b1, 8'd3, 8'd2);
        run(30, 1'b1);
        run_to_high_mid();
        step(1'b1, 1'b1, 8'd6, 8'd4);
        run(12, 1'b1);
        step(1'b1, 1'b1, 8'd0, 8'd5);
        run(25, 1'b1);
        for (int i = 0; i < 40 && !m_last_ps; i++) step(1'b1, 1'b0, 8'd0, 8'd0);
        run(15, 1'b0);
        run(3, 1'b0);
        run(25, 1'b1);
        step(1'b1, 1'b1, 8'd1, 8'd1);
        run(30, 1'b1);
        step(1'b1, 1'b1, 8'd255, 8'd255);
        run(1100, 1'b1);
        step(1'b1, 1'b1, 8'd6, 8'd4);
        run(520, 1'b1);
        step(1'b1, 1'b1, 8'd2, 8'd3);
        for (int i = 0; i < 40 && !(m_last_pwm == 0 && wave.size() > 1); i++) step(1'b1, 1'b0, 8'd0, 8'd0);
        step(1'b0, 1'b0, 8'd0, 8'd0);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_mid_low", {pwm_out, period_start, busy, cfg_ready, cfg_err}, 5'b00010);
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        run(2, 1'b0);
        run(40, 1'b1);
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
                 8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)));
        run(20, 1'b0);
        @(negedge clock);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pwm_duty_ctrl.md
Name: pwm_duty_ctrl

Overview:
Programmable duty-cycle waveform controller. It generates pwm_out with a run-time configurable high time and low time, in clock cycles. New settings arrive over a valid/ready config handshake and take effect only at a period boundary, so no period is ever glitched. Default configuration produces the 60% duty, 10-cycle waveform that the tb duty-cycle assertions check. The block drives clock-like enables and PWM outputs elsewhere in the design.

Parameters:
CNT_W, 8, width of the high/low cycle counts; legal range per phase is 1..2^CNT_W-1.
DEF_HIGH, 6, high-phase length in cycles after reset.
DEF_LOW, 4, low-phase length in cycles after reset.

Ports:
clock  in  1  sole clock; all logic is on the posedge.
reset_n  in  1  asynchronous, active-low reset.
enable  in  1  run request; level-sensitive.
cfg_valid  in  1  config offer.
cfg_ready  out  1  block can accept a config.
cfg_high  in  CNT_W  requested high-phase cycles.
cfg_low  in  CNT_W  requested low-phase cycles.
cfg_err  out  1  one-cycle pulse: offered config rejected.
pwm_out  out  1  generated waveform; registered.
period_start  out  1  one-cycle pulse on the first high cycle of each period.
busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync-to-clock deassert assumed upstream):
  - pwm_out=0, period_start=0, cfg_err=0, busy=0, cfg_ready=1.
  - State IDLE; active_high=DEF_HIGH, active_low=DEF_LOW; pending register empty.
- States: IDLE, HIGH, LOW. Down-counter cnt is CNT_W bits.
- IDLE:
  - pwm_out=0.
  - enable=1 sampled at edge t → at t+1: state HIGH, pwm_out=1, period_start=1, cnt=active_high-1.
- HIGH:
  - pwm_out=1.
  - cnt!=0: decrement.
  - cnt==0: next state LOW, pwm_out=0, cnt=active_low-1.
- LOW:
  - pwm_out=0.
  - cnt!=0: decrement.
  - cnt==0 (period boundary):
    - enable=1 → HIGH, period_start=1, cnt=high-1.
    - enable=0 → IDLE.
- Result: pwm_out is high for exactly active_high cycles, then low for exactly active_low cycles; period = high + low.
- Enable deassertion: never truncates a period. The block always completes LOW, then decides at the boundary. Re-asserting enable before the boundary continues seamlessly.
- Config handshake: accept when cfg_valid && cfg_ready at an edge.
  - Either field == 0 → reject.
    - cfg_err=1 for the next cycle only.
    - Pending register and cfg_ready are unchanged.
  - Otherwise → pending={cfg_high, cfg_low}, pending_valid=1, cfg_ready=0 from the next cycle.
  - cfg_ready = !pending_valid (registered).
- Apply point: every transition into HIGH (from IDLE or at a LOW boundary).
  - If pending_valid, copy pending → active first, so that period uses the new values and cnt loads from the new high.
  - Clear pending_valid; cfg_ready rises the following cycle.
- While IDLE, a pending config stays pending until the next start; the active values are untouched.
- Simultaneous accept and apply in the same edge: the apply uses the old pending content (empty → nothing applied). The newly accepted config is applied at the following boundary. Only possible when pending is empty, since cfg_ready=0 otherwise.
- Reset mid-period: immediate return to all reset values. Pending config is discarded and active reverts to DEF_*.
- No arithmetic beyond decrement; no overflow is possible since loads are ≥1.

Decomposition:
- Package pwm_duty_pkg holds:
  - state enum {IDLE, HIGH, LOW}
  - typedef struct packed {logic [CNT_W-1:0] high, low;} duty_cfg_t, with CNT_W as a package localparam default of 8.
  - DEF_HIGH/DEF_LOW defaults.
- One natural sub-module: pwm_cfg_shadow. It holds the pending register, the valid/ready handshake, zero-check/cfg_err, and the apply-on-strobe active register. The FSM and counter stay in the top.

Test Plan:
- Defaults, enable=1 from reset release, run 50 cycles → pwm_out high 6 / low 4 repeating; period_start every 10 cycles; 60% duty. Bind the existing check_ton/check_toff properties.
- Mid-HIGH, config {3,2} accepted → current period still 6/4; cfg_ready=0 until the next period_start; following periods are 3 high / 2 low; cfg_ready=1 one cycle after the apply.
- Config {0,5} offered → cfg_err pulses exactly 1 cycle; cfg_ready stays 1; waveform unchanged at 6/4.
- enable dropped on the 2nd high cycle → pwm_out stays high to cycle 6, low for 4, then IDLE with busy=0. Re-enable → first high cycle 1 cycle after enable is sampled, with period_start=1.
- Config {1,1} → pwm_out toggles every cycle (50%, period 2), period_start every 2 cycles. Config {255,255} → 255/255 with no wrap.
- reset_n asserted mid-LOW with a config pending → pwm_out=0 asynchronously, cfg_ready=1. After re-enable the waveform is 6/4 and the pending config is not applied.
